// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants for the next-PC generator.
package cpu_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t RESET_PC   = 32'h0000_0000;
  localparam pc_t EXC_VECTOR = 32'h8000_0004;
  localparam pc_t PC_INC     = 32'd4;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_JR,
    SEL_BR,
    SEL_J,
    SEL_PEND,
    SEL_HOLD,
    SEL_SEQ
  } pcsel_e;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic pc_t align_pc(input pc_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/hazard inputs and PC/flush outputs of the next-PC generator.
interface pc_gen_if #(parameter int CNT_W = 16);
  import cpu_pkg::*;

  logic             stall;
  logic             imem_ready;
  logic             branch_taken;
  pc_t              branch_target;
  logic             jump;
  pc_t              jump_target;
  logic             jr;
  pc_t              jr_target;
  logic             exception;
  pc_t              PC;
  logic             flush_IF_ID;
  logic             flush_ID_EX;
  logic             redirect_pending;
  logic             misaligned;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    input  stall, imem_ready, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception,
    output PC, flush_IF_ID, flush_ID_EX, redirect_pending, misaligned,
           redirect_count
  );

  modport slave (
    output stall, imem_ready, branch_taken, branch_target, jump, jump_target,
           jr, jr_target, exception,
    input  PC, flush_IF_ID, flush_ID_EX, redirect_pending, misaligned,
           redirect_count
  );

endinterface

// File: rtl/pc_sel_prio.sv
// Priority encoder choosing the next-PC source and the pipeline flushes.
module pc_sel_prio
  import cpu_pkg::*;
(
  input  logic   exception,
  input  logic   jr,
  input  logic   branch_taken,
  input  logic   jump,
  input  logic   pending,
  input  logic   stall,
  input  logic   imem_ready,
  output pcsel_e sel,
  output logic   accept,
  output logic   defer,
  output logic   flush_if_id,
  output logic   flush_id_ex
);

  always_comb begin
    sel         = SEL_SEQ;
    accept      = 1'b0;
    defer       = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (exception) begin
      sel         = SEL_EXC;
      accept      = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (jr || branch_taken) begin
      sel         = jr ? SEL_JR : SEL_BR;
      accept      = 1'b1;
      defer       = !imem_ready;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (jump) begin
      // ID-resolved: only the instruction behind it in IF/ID is wrong-path
      sel         = SEL_J;
      accept      = 1'b1;
      defer       = !imem_ready;
      flush_if_id = 1'b1;
    end else if (pending && imem_ready) begin
      sel = SEL_PEND;
    end else if (stall || !imem_ready) begin
      sel = SEL_HOLD;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator feeding IF: PC register, deferred-redirect FSM and counters.
// state   | meaning
// RUN     | no redirect outstanding
// PENDING | redirect accepted while imem stalled; pend_target waits for imem_ready
module pc_gen
  import cpu_pkg::*;
#(
  parameter pc_t RESET_PC   = cpu_pkg::RESET_PC,
  parameter pc_t EXC_VECTOR = cpu_pkg::EXC_VECTOR,
  parameter int  CNT_W      = 16
) (
  input  logic      clk,
  input  logic      reset,
  pc_gen_if.master  bus
);

  typedef enum logic {RUN, PENDING} state_e;

  state_e           state;
  pc_t              pc_reg;
  pc_t              pend_target;
  logic [CNT_W-1:0] cnt;
  logic             misaligned_q;

  pcsel_e sel;
  logic   accept;
  logic   defer;
  logic   fl_if_id;
  logic   fl_id_ex;
  logic   pending;
  pc_t    raw_target;
  pc_t    next_pc;

  assign pending = (state == PENDING);

  pc_sel_prio u_prio (
    .exception    (bus.exception),
    .jr           (bus.jr),
    .branch_taken (bus.branch_taken),
    .jump         (bus.jump),
    .pending      (pending),
    .stall        (bus.stall),
    .imem_ready   (bus.imem_ready),
    .sel          (sel),
    .accept       (accept),
    .defer        (defer),
    .flush_if_id  (fl_if_id),
    .flush_id_ex  (fl_id_ex)
  );

  always_comb begin
    raw_target = pend_target;
    case (sel)
      SEL_EXC: raw_target = EXC_VECTOR;
      SEL_JR:  raw_target = bus.jr_target;
      SEL_BR:  raw_target = bus.branch_target;
      SEL_J:   raw_target = bus.jump_target;
      default: raw_target = pend_target;
    endcase
  end

  always_comb begin
    next_pc = pc_reg + PC_INC;
    if (reset) begin
      // IF's first latch after reset must see RESET_PC+4
      next_pc = RESET_PC + PC_INC;
    end else begin
      case (sel)
        SEL_EXC:               next_pc = align_pc(raw_target);
        SEL_JR, SEL_BR, SEL_J: next_pc = defer ? pc_reg : align_pc(raw_target);
        SEL_PEND:              next_pc = pend_target;
        SEL_HOLD:              next_pc = pc_reg;
        default:               next_pc = pc_reg + PC_INC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc_reg       <= RESET_PC;
      pend_target  <= '0;
      cnt          <= '0;
      misaligned_q <= 1'b0;
    end else begin
      pc_reg       <= next_pc;
      misaligned_q <= accept && (raw_target[1:0] != 2'b00);
      if (accept && (cnt != {CNT_W{1'b1}}))
        cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      // a deferred redirect overwrites any older pending target
      if (sel == SEL_EXC) begin
        state <= RUN;
      end else if (accept && defer) begin
        state       <= PENDING;
        pend_target <= align_pc(raw_target);
      end else if (accept || sel == SEL_PEND) begin
        state <= RUN;
      end
    end
  end

  assign bus.PC               = next_pc;
  assign bus.flush_IF_ID      = !reset && fl_if_id;
  assign bus.flush_ID_EX      = !reset && fl_id_ex;
  assign bus.redirect_pending = pending;
  assign bus.misaligned       = misaligned_q;
  assign bus.redirect_count   = cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pc_gen_if #(.CNT_W(16)) bus ();

  pc_gen #(
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h8000_0004),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input logic ready);
    bus.stall         = 1'b0;
    bus.imem_ready    = ready;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    bus.jr            = 1'b0;
    bus.jr_target     = 32'h0;
    bus.exception     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_flush(input string tag, input logic f1, input logic f2);
    check_val({tag, "_fl_if_id"}, 32'(bus.flush_IF_ID), 32'(f1));
    check_val({tag, "_fl_id_ex"}, 32'(bus.flush_ID_EX), 32'(f2));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle(1'b1);
    tick();
    settle();
    check_val("rst_pc", bus.PC, 32'h4);
    check_flush("rst", 1'b0, 1'b0);
    check_val("rst_cnt", 32'(bus.redirect_count), 32'h0);
    check_val("rst_pend", 32'(bus.redirect_pending), 32'h0);
    check_val("rst_mis", 32'(bus.misaligned), 32'h0);
    tick();

    // sequential fetch out of reset
    reset = 1'b0;
    settle();
    check_val("seq_4", bus.PC, 32'h4);
    check_flush("seq", 1'b0, 1'b0);
    tick();
    check_val("seq_8", bus.PC, 32'h8);
    tick();
    check_val("seq_c", bus.PC, 32'hC);
    check_val("seq_cnt", 32'(bus.redirect_count), 32'h0);
    tick();
    check_val("seq_10", bus.PC, 32'h10);
    tick();

    // stall holds pc_reg=0x10 for two cycles
    bus.stall = 1'b1;
    settle();
    check_val("stall_1", bus.PC, 32'h10);
    tick();
    check_val("stall_2", bus.PC, 32'h10);
    tick();
    bus.stall = 1'b0;
    settle();
    check_val("stall_resume", bus.PC, 32'h14);
    tick(); tick(); tick();
    check_val("seq_20", bus.PC, 32'h20);
    tick();

    // branch overrides stall
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    bus.stall         = 1'b1;
    settle();
    check_val("br_pc", bus.PC, 32'h100);
    check_flush("br", 1'b1, 1'b1);
    tick();
    idle(1'b1);
    settle();
    check_val("br_cnt", 32'(bus.redirect_count), 32'h1);
    check_val("br_next", bus.PC, 32'h104);

    // jump to 0x40 with imem ready: only IF/ID flushed
    bus.jump        = 1'b1;
    bus.jump_target = 32'h40;
    settle();
    check_val("j_pc", bus.PC, 32'h40);
    check_flush("j", 1'b1, 1'b0);
    tick();

    // misaligned jump while imem not ready is deferred
    bus.jump_target = 32'h203;
    bus.imem_ready  = 1'b0;
    settle();
    check_val("jdef_pc", bus.PC, 32'h40);
    check_flush("jdef", 1'b1, 1'b0);
    tick();
    idle(1'b0);
    settle();
    check_val("jdef_pend", 32'(bus.redirect_pending), 32'h1);
    check_val("jdef_mis", 32'(bus.misaligned), 32'h1);
    check_val("jdef_hold", bus.PC, 32'h40);
    check_val("jdef_cnt", 32'(bus.redirect_count), 32'h3);
    tick();
    check_val("mis_pulse_end", 32'(bus.misaligned), 32'h0);
    bus.imem_ready = 1'b1;
    settle();
    check_val("pend_done_pc", bus.PC, 32'h200);
    check_flush("pend_done", 1'b0, 1'b0);
    tick();
    check_val("pend_run", 32'(bus.redirect_pending), 32'h0);
    check_val("pend_seq", bus.PC, 32'h204);

    // deferred branch to 0x300, then exception while imem not ready
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h300;
    bus.imem_ready    = 1'b0;
    settle();
    check_val("bdef_pc", bus.PC, 32'h200);
    check_flush("bdef", 1'b1, 1'b1);
    tick();
    idle(1'b0);
    bus.exception = 1'b1;
    settle();
    check_val("exc_pend_before", 32'(bus.redirect_pending), 32'h1);
    check_val("exc_pc", bus.PC, 32'h8000_0004);
    check_flush("exc", 1'b1, 1'b1);
    tick();
    idle(1'b1);
    settle();
    check_val("exc_pend_clr", 32'(bus.redirect_pending), 32'h0);
    check_val("exc_next", bus.PC, 32'h8000_0008);
    check_val("exc_cnt", 32'(bus.redirect_count), 32'h5);

    // jr beats branch beats jump
    bus.jr            = 1'b1;
    bus.jr_target     = 32'h500;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h600;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h700;
    settle();
    check_val("prio_pc", bus.PC, 32'h500);
    check_flush("prio", 1'b1, 1'b1);
    tick();

    // newer redirect overwrites pend_target; completion ignores stall
    idle(1'b0);
    bus.jump        = 1'b1;
    bus.jump_target = 32'h700;
    settle();
    check_val("ow_j_pc", bus.PC, 32'h500);
    tick();
    idle(1'b0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h800;
    settle();
    check_val("ow_pend", 32'(bus.redirect_pending), 32'h1);
    check_val("ow_br_pc", bus.PC, 32'h500);
    check_flush("ow_br", 1'b1, 1'b1);
    tick();
    idle(1'b1);
    bus.stall = 1'b1;
    settle();
    check_val("ow_done_pc", bus.PC, 32'h800);
    tick();
    idle(1'b1);
    settle();
    check_val("ow_run", 32'(bus.redirect_pending), 32'h0);
    check_val("ow_next", bus.PC, 32'h804);
    check_val("ow_cnt", 32'(bus.redirect_count), 32'h8);

    // saturate the redirect counter
    for (int i = 0; i < 65535; i++) begin
      bus.jump        = 1'b1;
      bus.jump_target = 32'h1000;
      tick();
    end
    idle(1'b1);
    settle();
    check_val("sat_full", 32'(bus.redirect_count), 32'hFFFF);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h2000;
    tick();
    idle(1'b1);
    settle();
    check_val("sat_hold", 32'(bus.redirect_count), 32'hFFFF);

    // wrap from the top of the address space
    bus.jump        = 1'b1;
    bus.jump_target = 32'hFFFF_FFFC;
    settle();
    check_val("wrap_j", bus.PC, 32'hFFFF_FFFC);
    tick();
    idle(1'b1);
    settle();
    check_val("wrap_0", bus.PC, 32'h0);
    tick();
    check_val("wrap_4", bus.PC, 32'h4);

    // reset while pending discards the target
    bus.jump        = 1'b1;
    bus.jump_target = 32'h900;
    bus.imem_ready  = 1'b0;
    tick();
    idle(1'b0);
    reset = 1'b1;
    settle();
    check_val("rstp_pc", bus.PC, 32'h4);
    check_flush("rstp", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    idle(1'b1);
    settle();
    check_val("rstp_pend", 32'(bus.redirect_pending), 32'h0);
    check_val("rstp_cnt", 32'(bus.redirect_count), 32'h0);
    check_val("rstp_after", bus.PC, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
